// File: rtl/flunky_csr_gpio.sv
// APB CSR block: core run/reset stretching, GPIO pin ownership between CSR and cores, 2-flop input sync.
// Optional macro FLUNKY_GPIO_IRQ_EN adds rising-edge detect, IRQ_EN/IRQ_STAT (W1C) and the irq output.
module flunky_csr_gpio #(
  parameter int GPIO_WIDTH = 8,
  parameter int NUM_CORES  = 2,
  parameter int RST_CYCLES = 16
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [11:0]                     paddr,
  input  logic                            psel,
  input  logic                            penable,
  input  logic                            pwrite,
  input  logic [31:0]                     pwdata,
  output logic [31:0]                     prdata,
  output logic                            pready,
  output logic [NUM_CORES-1:0]            core_resetn,
  input  logic [NUM_CORES*GPIO_WIDTH-1:0] core_gpo,
  input  logic [NUM_CORES*GPIO_WIDTH-1:0] core_gpen,
  output logic [GPIO_WIDTH-1:0]           core_gpi,
  inout  wire  [GPIO_WIDTH-1:0]           GPIO,
  output logic                            irq
);

  localparam logic [2:0] A_CTRL  = 3'd0;
  localparam logic [2:0] A_OUT   = 3'd1;
  localparam logic [2:0] A_OE    = 3'd2;
  localparam logic [2:0] A_IN    = 3'd3;
  localparam logic [2:0] A_HOST  = 3'd4;
  localparam logic [2:0] A_IEN   = 3'd5;
  localparam logic [2:0] A_ISTAT = 3'd6;
  localparam logic [2:0] A_STR   = 3'd7;
  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES);

  logic [NUM_CORES-1:0]       ctrl_q, ctrl_d;
  logic [GPIO_WIDTH-1:0]      out_q, out_d;
  logic [GPIO_WIDTH-1:0]      oe_q, oe_d;
  logic [GPIO_WIDTH-1:0]      host_q, host_d;
  logic [GPIO_WIDTH-1:0]      sync1_q, sync1_d;
  logic [GPIO_WIDTH-1:0]      sync2_q, sync2_d;
  logic [NUM_CORES-1:0][7:0]  cnt_q, cnt_d;
  logic [NUM_CORES-1:0]       stretch;
  logic [GPIO_WIDTH-1:0]      irq_en_rd, irq_stat_rd;
  logic [GPIO_WIDTH-1:0]      pin_en, pin_val;
  logic                       wr;
  logic [2:0]                 sel;
  logic                       unused_ok;

  assign wr        = psel & penable & pwrite;
  assign sel       = paddr[4:2];
  assign pready    = 1'b1;
  assign core_gpi  = sync2_q;
  assign unused_ok = ^{paddr[11:5], paddr[1:0], pwdata, core_gpo, core_gpen};

  always_comb begin
    ctrl_d  = ctrl_q;
    out_d   = out_q;
    oe_d    = oe_q;
    host_d  = host_q;
    sync1_d = GPIO;
    sync2_d = sync1_q;
    if (wr) begin
      case (sel)
        A_CTRL:  ctrl_d = pwdata[NUM_CORES-1:0];
        A_OUT:   out_d  = pwdata[GPIO_WIDTH-1:0];
        A_OE:    oe_d   = pwdata[GPIO_WIDTH-1:0];
        A_HOST:  host_d = pwdata[GPIO_WIDTH-1:0];
        default: ;
      endcase
    end
    // Any CTRL write with bit k clear restarts the reset stretch, even mid-count.
    for (int k = 0; k < NUM_CORES; k++) begin
      cnt_d[k] = (cnt_q[k] != 8'd0) ? cnt_q[k] - 8'd1 : 8'd0;
      if (wr && (sel == A_CTRL) && !pwdata[k]) cnt_d[k] = RST_LOAD;
      stretch[k]     = (cnt_q[k] != 8'd0);
      core_resetn[k] = ctrl_q[k] && (cnt_q[k] == 8'd0);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_q  <= '0;
      out_q   <= '0;
      oe_q    <= '0;
      host_q  <= '1;
      sync1_q <= '0;
      sync2_q <= '0;
      cnt_q   <= {NUM_CORES{RST_LOAD}};
    end else begin
      ctrl_q  <= ctrl_d;
      out_q   <= out_d;
      oe_q    <= oe_d;
      host_q  <= host_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    prdata = '0;
    if (psel && !pwrite) begin
      case (sel)
        A_CTRL:  prdata = 32'(ctrl_q);
        A_OUT:   prdata = 32'(out_q);
        A_OE:    prdata = 32'(oe_q);
        A_IN:    prdata = 32'(sync2_q);
        A_HOST:  prdata = 32'(host_q);
        A_IEN:   prdata = 32'(irq_en_rd);
        A_ISTAT: prdata = 32'(irq_stat_rd);
        A_STR:   prdata = 32'(stretch);
        default: prdata = '0;
      endcase
    end
  end

  // Core-owned pins are interleaved so every core gets a share of the pads.
  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
    localparam int OWN = (i % NUM_CORES) * GPIO_WIDTH + i;
    assign pin_en[i]  = host_q[i] ? oe_q[i]  : core_gpen[OWN];
    assign pin_val[i] = host_q[i] ? out_q[i] : core_gpo[OWN];
    assign GPIO[i]    = pin_en[i] ? pin_val[i] : 1'bz;
  end

`ifdef FLUNKY_GPIO_IRQ_EN
  logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d;
  logic [GPIO_WIDTH-1:0] irq_stat_q, irq_stat_d;
  logic [GPIO_WIDTH-1:0] prev_q, prev_d;
  logic [GPIO_WIDTH-1:0] rise, w1c;
  logic                  irq_q, irq_d;

  // A new edge wins over a coincident W1C so no event is lost.
  always_comb begin
    prev_d     = sync2_q;
    rise       = sync2_q & ~prev_q;
    w1c        = (wr && (sel == A_ISTAT)) ? pwdata[GPIO_WIDTH-1:0] : '0;
    irq_en_d   = (wr && (sel == A_IEN)) ? pwdata[GPIO_WIDTH-1:0] : irq_en_q;
    irq_stat_d = (irq_stat_q & ~w1c) | (rise & irq_en_q);
    irq_d      = |irq_stat_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_en_q   <= '0;
      irq_stat_q <= '0;
      prev_q     <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_stat_q <= irq_stat_d;
      prev_q     <= prev_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_en_rd   = irq_en_q;
  assign irq_stat_rd = irq_stat_q;
  assign irq         = irq_q;
`else
  assign irq_en_rd   = '0;
  assign irq_stat_rd = '0;
  assign irq         = 1'b0;
`endif

endmodule

// File: tb/tb_flunky_csr_gpio.sv
// Scoreboard bench for flunky_csr_gpio: stimulus queues expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_flunky_csr_gpio;
  localparam int GW = 8;
  localparam int NC = 2;
  localparam logic [11:0] A_CTRL  = 12'h000;
  localparam logic [11:0] A_OUT   = 12'h004;
  localparam logic [11:0] A_OE    = 12'h008;
  localparam logic [11:0] A_IN    = 12'h00C;
  localparam logic [11:0] A_HOST  = 12'h010;
  localparam logic [11:0] A_IEN   = 12'h014;
  localparam logic [11:0] A_ISTAT = 12'h018;
  localparam logic [11:0] A_STR   = 12'h01C;
  localparam int K_RD = 0, K_CRN = 1, K_GPIO = 2, K_IRQ = 3, K_PRD = 4, K_GPI = 5, K_RDY = 6;
`ifdef FLUNKY_GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  typedef struct {
    string       name;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic [11:0]       paddr;
  logic              psel, penable, pwrite;
  logic [31:0]       pwdata;
  logic [31:0]       prdata;
  logic              pready;
  logic [NC-1:0]     core_resetn;
  logic [NC*GW-1:0]  core_gpo, core_gpen;
  logic [GW-1:0]     core_gpi;
  wire  [GW-1:0]     gpio;
  logic              irq;
  logic [GW-1:0]     tb_oe, tb_val;
  logic              probe_vld, fin_req;

  exp_t        sb_q[$];
  exp_t        e;
  logic [31:0] act;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < GW; i++) begin : g_pad
    assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    pullup pu (gpio[i]);
  end

  flunky_csr_gpio #(.GPIO_WIDTH(GW), .NUM_CORES(NC), .RST_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .paddr(paddr), .psel(psel), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .core_resetn(core_resetn), .core_gpo(core_gpo), .core_gpen(core_gpen),
    .core_gpi(core_gpi), .GPIO(gpio), .irq(irq)
  );

  function automatic logic [31:0] observe(input int k);
    case (k)
      K_CRN:   return 32'(core_resetn);
      K_GPIO:  return 32'(gpio);
      K_IRQ:   return 32'(irq);
      K_GPI:   return 32'(core_gpi);
      K_RDY:   return 32'(pready);
      default: return prdata;
    endcase
  endfunction

  // Monitor: read access phases and probe strobes are the points where DUT output is presented.
  always @(negedge clk) begin
    if (psel && penable && !pwrite) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: got %0h, no expectation queued", prdata);
      end else begin
        e = sb_q.pop_front();
        if (prdata !== e.val) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, prdata, e.val);
        end
      end
    end else if (probe_vld) begin
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        act = observe(e.kind);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, act, e.val);
        end
      end
    end
    if (fin_req) begin
      checks++;
      if (sb_q.size() != 0) begin
        errors++;
        $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string nm, input int k, input logic [31:0] v);
    exp_t x;
    x.name = nm;
    x.kind = k;
    x.val  = v;
    sb_q.push_back(x);
  endtask

  // Checks the current cycle's outputs at the negedge and advances one clock.
  task automatic sample();
    probe_vld = 1'b1;
    @(negedge clk);
    #1;
    probe_vld = 1'b0;
    tick();
  endtask

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, input logic [31:0] v, input string nm);
    expect_v(nm, K_RD, v);
    paddr = a; pwrite = 1'b0; psel = 1'b1; penable = 1'b0;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; paddr = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
    core_gpo = '0; core_gpen = '0; tb_oe = '0; tb_val = '0; probe_vld = 1'b0; fin_req = 1'b0;
    tick();
    tick();
    expect_v("rst_core_resetn", K_CRN, 32'h0);
    expect_v("rst_irq", K_IRQ, 32'h0);
    expect_v("rst_prdata", K_PRD, 32'h0);
    expect_v("rst_gpio_z", K_GPIO, 32'hFF);
    expect_v("rst_gpi", K_GPI, 32'h0);
    expect_v("pready", K_RDY, 32'h1);
    sample();
    resetn = 1'b1;

    // Run both cores right after reset: release 16 edges after reset deassertion.
    apb_write(A_CTRL, 32'h3);
    apb_read(A_STR, 32'h3, "stretch_busy");
    for (int c = 4; c <= 17; c++) begin
      expect_v($sformatf("crn_boot_c%0d", c), K_CRN, (c >= 16) ? 32'h3 : 32'h0);
      sample();
    end
    apb_read(A_STR, 32'h0, "stretch_done");
    apb_read(A_CTRL, 32'h3, "ctrl_rb");

    // Clear core 0, re-run it 5 cycles later: still exactly 16 cycles low.
    apb_write(A_CTRL, 32'h1);
    expect_v("crn_core0_only", K_CRN, 32'h1);
    sample();
    apb_write(A_CTRL, 32'h0);
    for (int c = 0; c < 3; c++) begin
      expect_v($sformatf("crn_clr_c%0d", c), K_CRN, 32'h0);
      sample();
    end
    apb_write(A_CTRL, 32'h1);
    for (int c = 5; c <= 17; c++) begin
      expect_v($sformatf("crn_rerun_c%0d", c), K_CRN, (c >= 16) ? 32'h1 : 32'h0);
      sample();
    end

    // Pin ownership: CSR-driven, then core-driven interleave.
    apb_write(A_HOST, 32'hFF);
    apb_write(A_OE, 32'h0F);
    apb_write(A_OUT, 32'h05);
    expect_v("gpio_host", K_GPIO, 32'hF5);
    sample();
    apb_read(12'h104, 32'h05, "out_alias");
    core_gpo  = {8'hFF, 8'h14};
    core_gpen = {8'hFF, 8'hFF};
    apb_write(A_HOST, 32'h00);
    expect_v("gpio_cores", K_GPIO, 32'hBE);
    sample();
    apb_read(A_IN, 32'hBE, "in_cores");
    expect_v("gpi_cores", K_GPI, 32'hBE);
    sample();
    core_gpo = '0; core_gpen = '0;

    // Rising edge on pin 2 through the synchronizer into IRQ_STAT and irq.
    apb_write(A_OE, 32'h00);
    tb_oe = 8'h04; tb_val = 8'h00;
    apb_write(A_IEN, 32'h04);
    tick();
    tick();
    apb_read(A_ISTAT, 32'h0, "istat_idle");
    tb_val = 8'h04;
    expect_v("gpi_r0", K_GPI, 32'hFB);
    expect_v("irq_r0", K_IRQ, 32'h0);
    sample();
    expect_v("gpi_r1", K_GPI, 32'hFB);
    sample();
    expect_v("gpi_r2", K_GPI, 32'hFF);
    sample();
    expect_v("irq_r3", K_IRQ, 32'h0);
    sample();
    expect_v("irq_r4", K_IRQ, IRQ_ON ? 32'h1 : 32'h0);
    sample();
    apb_read(A_IN, 32'hFF, "in_pin2");
    apb_read(A_ISTAT, IRQ_ON ? 32'h04 : 32'h0, "istat_set");
    apb_read(A_IEN, IRQ_ON ? 32'h04 : 32'h0, "ien_rb");
    apb_write(A_ISTAT, 32'h04);
    expect_v("irq_w1c_w0", K_IRQ, IRQ_ON ? 32'h1 : 32'h0);
    sample();
    expect_v("irq_w1c_w1", K_IRQ, 32'h0);
    sample();
    apb_read(A_ISTAT, 32'h0, "istat_cleared");

    // W1C landing on the same edge as a new rise keeps the bit.
    tb_val = 8'h00;
    for (int c = 0; c < 4; c++) tick();
    tb_val = 8'h04;
    tick();
    apb_write(A_ISTAT, 32'h04);
    apb_read(A_ISTAT, IRQ_ON ? 32'h04 : 32'h0, "istat_w1c_race");
    apb_write(A_ISTAT, 32'h04);
    apb_read(A_ISTAT, 32'h0, "istat_w1c_plain");

    // Setup-only and unselected accesses must not commit.
    paddr = A_OUT; pwdata = 32'hAA; pwrite = 1'b1; psel = 1'b1; penable = 1'b0;
    tick(); tick(); tick();
    paddr = A_CTRL; pwdata = 32'h0;
    tick();
    psel = 1'b0; penable = 1'b1; paddr = A_OUT; pwdata = 32'hAA;
    tick();
    penable = 1'b0; pwrite = 1'b0;
    apb_read(A_OUT, 32'h05, "out_no_commit");
    apb_read(A_CTRL, 32'h1, "ctrl_no_commit");

    // Asynchronous reset in the middle of a reset stretch.
    tb_oe = '0;
    apb_write(A_HOST, 32'hFF);
    apb_write(A_OE, 32'h0F);
    expect_v("gpio_pre_rst", K_GPIO, 32'hF5);
    sample();
    apb_write(A_CTRL, 32'h0);
    tick(); tick(); tick();
    resetn = 1'b0;
    #1;
    expect_v("midrst_crn", K_CRN, 32'h0);
    expect_v("midrst_gpio_z", K_GPIO, 32'hFF);
    expect_v("midrst_irq", K_IRQ, 32'h0);
    expect_v("midrst_prdata", K_PRD, 32'h0);
    sample();
    apb_read(A_HOST, 32'hFF, "midrst_host");
    apb_read(A_OE, 32'h0, "midrst_oe");
    apb_read(A_OUT, 32'h0, "midrst_out");
    apb_read(A_STR, 32'h3, "midrst_stretch");
    apb_read(A_IN, 32'h0, "midrst_in");
    resetn = 1'b1;
    tick();

    fin_req = 1'b1;
    @(negedge clk);
    #1;
    fin_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
